// File: rtl/spi_matrix_loader_mc.sv
// Loads matrix payloads from an SPI word stream into per-slot memories.
// A header word selects a slot and its dimensions; the next rows*cols words are written in order.
module spi_matrix_loader_mc #(
  parameter int DATA_W  = 32,
  parameter int NUM_MAT = 4,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  frame_abort,
  output logic                  wr_en,
  output logic [3:0]            wr_sel,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [NUM_MAT-1:0]    mat_ready,
  output logic [NUM_MAT*24-1:0] mat_dims,
  output logic                  busy,
  output logic                  err_valid,
  output logic [1:0]            err_code
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e               state_q;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 wr_en_q;
  logic [3:0]           wr_sel_q;
  logic [ADDR_W-1:0]    wr_addr_q;
  logic [DATA_W-1:0]    wr_data_q;
  logic [NUM_MAT-1:0]   mat_ready_q;
  logic [NUM_MAT*24-1:0] mat_dims_q;
  logic                 err_valid_q;
  logic [1:0]           err_code_q;
  logic [3:0]           id_q;
  logic [11:0]          rows_q;
  logic [11:0]          cols_q;
  logic [23:0]          size_q;
  logic [12:0]          count_q;
  logic [23:0]          drain_q;

  logic                 accept_s;
  logic                 id_ok_s;
  logic                 last_s;
  logic [23:0]          size_s;

  assign accept_s = in_valid && in_ready_q;
  assign size_s   = 24'(rows_q) * 24'(cols_q);
  assign id_ok_s  = ({1'b0, id_q} < 5'(NUM_MAT));
  assign last_s   = ({11'd0, count_q} == (size_q - 24'd1));

  // Frame-level FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= 4'd0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      mat_ready_q <= '0;
      mat_dims_q  <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'd0;
      id_q        <= 4'd0;
      rows_q      <= 12'd0;
      cols_q      <= 12'd0;
      size_q      <= 24'd0;
      count_q     <= 13'd0;
      drain_q     <= 24'd0;
    end else begin
      wr_en_q     <= 1'b0;
      err_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          if (accept_s) begin
            if (in_data[31:28] != 4'hA) begin
              err_valid_q <= 1'b1;
              err_code_q  <= 2'd1;
            end else begin
              id_q       <= in_data[27:24];
              rows_q     <= in_data[23:12];
              cols_q     <= in_data[11:0];
              state_q    <= ST_CHECK;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end
        ST_CHECK: begin
          in_ready_q <= 1'b1;
          size_q     <= size_s;
          if (frame_abort) begin
            for (int k = 0; k < NUM_MAT; k++) begin
              if (id_q == 4'(k)) begin
                mat_ready_q[k] <= 1'b0;
              end
            end
            err_valid_q <= 1'b1;
            err_code_q  <= 2'd3;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
          end else if (!id_ok_s || size_s == 24'd0) begin
            err_valid_q <= 1'b1;
            err_code_q  <= 2'd1;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
          end else if (size_s > 24'(DEPTH)) begin
            err_valid_q <= 1'b1;
            err_code_q  <= 2'd2;
            drain_q     <= size_s;
            state_q     <= ST_DRAIN;
          end else begin
            for (int k = 0; k < NUM_MAT; k++) begin
              if (id_q == 4'(k)) begin
                mat_ready_q[k]         <= 1'b0;
                mat_dims_q[24*k +: 24] <= {rows_q, cols_q};
              end
            end
            count_q <= 13'd0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // An abort takes priority over a word accepted in the same cycle.
          if (frame_abort) begin
            err_valid_q <= 1'b1;
            err_code_q  <= 2'd3;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
          end else if (accept_s) begin
            wr_en_q   <= 1'b1;
            wr_sel_q  <= id_q;
            wr_addr_q <= count_q[ADDR_W-1:0];
            wr_data_q <= in_data;
            count_q   <= count_q + 13'd1;
            if (last_s) begin
              for (int k = 0; k < NUM_MAT; k++) begin
                if (id_q == 4'(k)) begin
                  mat_ready_q[k] <= 1'b1;
                end
              end
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (frame_abort) begin
            err_valid_q <= 1'b1;
            err_code_q  <= 2'd3;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
          end else if (accept_s) begin
            drain_q <= drain_q - 24'd1;
            if (drain_q == 24'd1) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign wr_en     = wr_en_q;
  assign wr_sel    = wr_sel_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign mat_ready = mat_ready_q;
  assign mat_dims  = mat_dims_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: doc/spi_matrix_loader_mc.md
SPI_MATRIX_LOADER_MC -- requirements
Module: spi_matrix_loader_mc

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W, 32, payload word width; must be >= 32.
  NUM_MAT, 4, number of matrix slots; 1..16.
  DEPTH, 64, words per slot; power of two, <= 4096.
  ADDR_W, clog2(DEPTH), slot address width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  clock.
  rst_n  in  1  reset, asynchronous, active-low.
  in_data  in  DATA_W  word from the SPI word receiver.
  in_valid  in  1  in_data valid.
  in_ready  out  1  block accepts word this cycle.
  frame_abort  in  1  single-cycle pulse: chip-select released mid-frame.
  wr_en  out  1  slot memory write strobe.
  wr_sel  out  4  target slot index.
  wr_addr  out  ADDR_W  word index within slot.
  wr_data  out  DATA_W  word to write.
  mat_ready  out  NUM_MAT  per-slot "load complete" flag.
  mat_dims  out  NUM_MAT*24  per slot {rows[11:0], cols[11:0]}; slot k at bits [24k+23:24k].
  busy  out  1  high in any state other than IDLE.
  err_valid  out  1  single-cycle error pulse.
  err_code  out  2  1 = bad header, 2 = size overflow, 3 = abort; held until the next error.

Function
REQ-003 A word transfers only on a cycle with in_valid and in_ready both high.
REQ-004 Header word (low 32 bits): [31:28] = 4'hA for a load command; [27:24] = slot id; [23:12] = rows; [11:0] = cols.
REQ-005 FSM states: IDLE, CHECK, LOAD, DRAIN.
REQ-006 in_ready SHALL be 1 in IDLE, LOAD and DRAIN, and 0 in CHECK.
REQ-007 IDLE, header with opcode not equal to 4'hA: discard it, stay in IDLE, pulse err_valid with err_code = 1.
REQ-008 IDLE, header with opcode 4'hA: latch id, rows and cols, then go to CHECK.
REQ-009 CHECK lasts one cycle. It computes size = rows*cols as a 24-bit product, then:
  - id >= NUM_MAT, or size == 0: err_code = 1, go to IDLE.
  - size > DEPTH: err_code = 2, go to DRAIN with the discard count set to size.
  - otherwise: clear mat_ready[id], update mat_dims[id], reset the word count to 0, go to LOAD.
REQ-010 LOAD, each accepted word: on the next cycle wr_en = 1, wr_sel = id, wr_addr = count, wr_data = word. count then increments.
REQ-011 LOAD, accepted word with count == size-1: go to IDLE. mat_ready[id] rises in the same cycle as that word's wr_en.
REQ-012 DRAIN: accepted words are discarded with no wr_en. Go to IDLE after size words.
REQ-013 frame_abort in LOAD, CHECK or DRAIN: go to IDLE on the next cycle; err_code = 3; mat_ready[id] stays 0; any pending registered write still completes.
REQ-014 frame_abort in IDLE has no effect.
REQ-015 If frame_abort and an accepted word coincide in LOAD, the abort wins and the word is not written.
REQ-016 Flags of slots not addressed by the current header are never changed.
REQ-017 Reloading a ready slot clears its flag in CHECK and sets it again only on successful completion.
REQ-018 count SHALL be 13 bits wide and SHALL never wrap within a legal load.
REQ-019 In DRAIN the discard counter SHALL be 24 bits wide.
REQ-020 wr_en SHALL never assert outside the cycle after an accepted LOAD word.

Reset
REQ-021 When rst_n is low: state = IDLE; in_ready = 0; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0; mat_ready = 0; mat_dims = 0; busy = 0; err_valid = 0; err_code = 0; all counters = 0.
REQ-022 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-023 Reset mid-load discards all partial state; slot memory contents are not the block's concern.

Verification
REQ-024 Header 0xA1002003 followed by 6 words D0..D5 -> 6 writes, wr_sel = 1, wr_addr 0..5; mat_ready = 4'b0010 coincident with the 6th wr_en; mat_dims slot 1 = {2, 3}.
REQ-025 Header 0xA0009009 (81 words > DEPTH 64), then 81 words -> err_code = 2 pulse, no wr_en, busy drops after the 81st word; next header is accepted normally.
REQ-026 Header 0x30001001, then header 0xA7001001 -> two err_valid pulses, both err_code = 1; FSM in IDLE; mat_ready unchanged.
REQ-027 Load slot 2 fully; reload slot 2 (2x2); abort after 2 words -> mat_ready[2] = 0, err_code = 3, exactly 2 writes in the second load.
REQ-028 Random in_valid gaps, 8x8 into slot 3 -> 64 writes in order, addresses 0..63, no writes while in_valid is low.
REQ-029 Assert rst_n low during LOAD at word 5 -> all outputs take reset values immediately; a subsequent full load succeeds.
